// File: rtl/mat_load_if.sv
// mat_load_if -- element stream and memory beat bus used by the matrix load
// sequencer.
//
//   master : the sequencer. It drives in_rdy and the mem_* beat, and receives
//            in_vld/in_data and mem_rdy.
//   slave  : the upstream source and memory side, which drive in_vld/in_data
//            and mem_rdy.
//
// Signals
//   in_vld, in_rdy, in_data   upstream element handshake (DATA_WIDTH data)
//   mem_vld, mem_rdy          memory beat handshake
//   mem_we                    beat is a write (0 = compute trigger beat)
//   mem_addr                  bit offset of the element (index * DATA_WIDTH)
//   mem_data                  element written
interface mat_load_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_vld;
  logic                  in_rdy;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  mem_vld;
  logic                  mem_rdy;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;

  modport master (
    input  in_vld, in_data, mem_rdy,
    output in_rdy, mem_vld, mem_we, mem_addr, mem_data
  );

  modport slave (
    output in_vld, in_data, mem_rdy,
    input  in_rdy, mem_vld, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/mat_load_sequencer.sv
// mat_load_sequencer -- loads a MAT_DIM x MAT_DIM weight matrix W and then an
// X_DEPTH element vector X from an upstream element stream into memory. It
// then issues one non-write "compute" beat and pulses done.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle request to begin a W-then-X load (honoured in IDLE only)
//   abort      cancel the current sequence; wins over start and transfers
//   bus        mat_load_if.master: element input handshake and memory beat
//   load_state 0 IDLE, 1 LOAD_W, 2 LOAD_X, 3 COMPUTE
//   done       one-cycle pulse after the compute beat is accepted
//   stall_cnt  memory back-pressure cycle count
//
// Build option
//   STALL_CNT_EN  when defined, stall_cnt counts cycles with mem_vld=1 and
//                 mem_rdy=0, saturates at 16'hFFFF, and clears on start.
//                 Otherwise stall_cnt is tied to 0.
module mat_load_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAT_DIM    = 4,
  parameter int X_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  mat_load_if.master        bus,
  output logic [1:0]        load_state,
  output logic              done,
  output logic [15:0]       stall_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD_W  = 2'd1;
  localparam logic [1:0] LOAD_X  = 2'd2;
  localparam logic [1:0] COMPUTE = 2'd3;

  localparam int W_LEN   = MAT_DIM * MAT_DIM;
  localparam int MAX_LEN = (W_LEN > X_DEPTH) ? W_LEN : X_DEPTH;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(W_LEN - 1);
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(X_DEPTH - 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic                  mem_vld_q;
  logic                  mem_we_q;
  logic [DATA_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic                  in_rdy_c;
  logic                  accept;
  logic                  beat_taken;

  function automatic logic [DATA_WIDTH-1:0] addr_of(input logic [CNT_W-1:0] idx);
    return DATA_WIDTH'(int'(idx) * DATA_WIDTH);
  endfunction

  // Accept a new element only while loading and when the beat register is
  // free or draining this cycle. Abort blocks the transfer so the upstream
  // side never sees an element accepted that is then thrown away.
  always_comb begin
    in_rdy_c   = ((state == LOAD_W) || (state == LOAD_X)) && !abort &&
                 (!mem_vld_q || bus.mem_rdy);
    accept     = bus.in_vld && in_rdy_c;
    beat_taken = mem_vld_q && bus.mem_rdy;
  end

  assign bus.in_rdy   = in_rdy_c;
  assign bus.mem_vld  = mem_vld_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign load_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_vld_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done       <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_vld_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (beat_taken) mem_vld_q <= 1'b0;

      // Element accepted this edge becomes the write beat for the next cycle.
      if (accept) begin
        mem_vld_q  <= 1'b1;
        mem_we_q   <= 1'b1;
        mem_addr_q <= addr_of(cnt);
        mem_data_q <= bus.in_data;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD_W;
            cnt   <= '0;
          end
        end
        LOAD_W: begin
          if (accept) begin
            if (cnt == W_LAST) begin
              state <= LOAD_X;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        LOAD_X: begin
          if (accept) begin
            if (cnt == X_LAST) begin
              state <= COMPUTE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          // COMPUTE: the last X write is still in the beat register on entry.
          // Once it drains, replace it with the read-type compute beat. When
          // that beat is accepted, finish.
          if (mem_vld_q && !mem_we_q) begin
            if (bus.mem_rdy) begin
              done      <= 1'b1;
              state     <= IDLE;
              mem_vld_q <= 1'b0;
            end
          end else if (!mem_vld_q || bus.mem_rdy) begin
            mem_vld_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
          end
        end
      endcase
    end
  end

`ifdef STALL_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start && (state == IDLE)) begin
      stall_q <= '0;
    end else if (mem_vld_q && !bus.mem_rdy) begin
      stall_q <= sat_inc16(stall_q);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mat_load_sequencer.sv
// tb_mat_load_sequencer -- directed bench for mat_load_sequencer. It covers
// the nominal W/X load from a vector table, then runs hand-written sequences
// for back-pressure, abort, ignored start and asynchronous reset.
module tb_mat_load_sequencer;
  localparam int DW = 8;

`ifdef STALL_CNT_EN
  localparam logic [15:0] STALL_EXP = 16'd3;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
`endif

  typedef struct {
    logic [DW-1:0] data;      // element driven on in_data
    logic [DW-1:0] addr;      // expected mem_addr of its write beat
    logic [1:0]    state;     // expected load_state after it is accepted
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [1:0]  load_state;
  logic        done;
  logic [15:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int edges  = 0;
  int first_edge;
  vec_t vecs[20];

  mat_load_if #(.DATA_WIDTH(DW)) bus ();

  mat_load_sequencer #(.DATA_WIDTH(DW), .MAT_DIM(4), .X_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .bus        (bus),
    .load_state (load_state),
    .done       (done),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " load_state"}, 32'(load_state), 0);
    chk({tag, " in_rdy"},     32'(bus.in_rdy), 0);
    chk({tag, " mem_vld"},    32'(bus.mem_vld), 0);
    chk({tag, " mem_we"},     32'(bus.mem_we), 0);
    chk({tag, " mem_addr"},   32'(bus.mem_addr), 0);
    chk({tag, " mem_data"},   32'(bus.mem_data), 0);
    chk({tag, " done"},       32'(done), 0);
    chk({tag, " stall_cnt"},  32'(stall_cnt), 0);
  endtask

  // Present one element with mem_rdy=1 and check the resulting write beat.
  task automatic feed(input string tag, input logic [DW-1:0] d,
                      input logic [DW-1:0] exp_addr, input logic [1:0] exp_state);
    bus.in_data = d;
    bus.in_vld  = 1'b1;
    #1;
    chk({tag, " in_rdy"}, 32'(bus.in_rdy), 1);
    tick();
    chk({tag, " mem_vld"},    32'(bus.mem_vld), 1);
    chk({tag, " mem_we"},     32'(bus.mem_we), 1);
    chk({tag, " mem_addr"},   32'(bus.mem_addr), 32'(exp_addr));
    chk({tag, " mem_data"},   32'(bus.mem_data), 32'(d));
    chk({tag, " load_state"}, 32'(load_state), 32'(exp_state));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // W elements 0..15 at offsets 0..120, then X elements 0..3 at 0..24.
    // W element 15 switches the state to LOAD_X on its accept edge, and
    // X element 3 switches it to COMPUTE.
    vecs[0]  = '{8'h11, 8'd0,   2'd1};
    vecs[1]  = '{8'h22, 8'd8,   2'd1};
    vecs[2]  = '{8'h33, 8'd16,  2'd1};
    vecs[3]  = '{8'h44, 8'd24,  2'd1};
    vecs[4]  = '{8'h55, 8'd32,  2'd1};
    vecs[5]  = '{8'h66, 8'd40,  2'd1};
    vecs[6]  = '{8'h77, 8'd48,  2'd1};
    vecs[7]  = '{8'h88, 8'd56,  2'd1};
    vecs[8]  = '{8'h99, 8'd64,  2'd1};
    vecs[9]  = '{8'hAA, 8'd72,  2'd1};
    vecs[10] = '{8'hBB, 8'd80,  2'd1};
    vecs[11] = '{8'hCC, 8'd88,  2'd1};
    vecs[12] = '{8'hDD, 8'd96,  2'd1};
    vecs[13] = '{8'hEE, 8'd104, 2'd1};
    vecs[14] = '{8'hF1, 8'd112, 2'd1};
    vecs[15] = '{8'hF2, 8'd120, 2'd2};
    vecs[16] = '{8'h01, 8'd0,   2'd2};
    vecs[17] = '{8'h02, 8'd8,   2'd2};
    vecs[18] = '{8'h03, 8'd16,  2'd2};
    vecs[19] = '{8'h04, 8'd24,  2'd3};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    bus.in_vld = 1'b0; bus.in_data = '0; bus.mem_rdy = 1'b1;
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Nominal flow.
    pulse_start();
    chk("start load_state", 32'(load_state), 1);
    for (int i = 0; i < 20; i++) begin
      feed($sformatf("nom[%0d]", i), vecs[i].data, vecs[i].addr, vecs[i].state);
      if (i == 0) first_edge = edges;
    end
    bus.in_vld = 1'b0;
    tick();
    chk("cmp beat mem_vld",  32'(bus.mem_vld), 1);
    chk("cmp beat mem_we",   32'(bus.mem_we), 0);
    chk("cmp beat mem_addr", 32'(bus.mem_addr), 0);
    chk("cmp beat mem_data", 32'(bus.mem_data), 0);
    chk("cmp beat done",     32'(done), 0);
    tick();
    chk("done pulse",        32'(done), 1);
    chk("done load_state",   32'(load_state), 0);
    chk("done mem_vld",      32'(bus.mem_vld), 0);
    chk("done latency",      32'(edges - first_edge), 21);
    tick();
    chk("done one cycle",    32'(done), 0);

    // Abort wins over start in the same cycle.
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort+start state", 32'(load_state), 0);

    // Back-pressure on W element 5.
    pulse_start();
    for (int i = 0; i < 6; i++)
      feed($sformatf("bp[%0d]", i), vecs[i].data, vecs[i].addr, 2'd1);
    bus.mem_rdy = 1'b0;
    bus.in_data = 8'h77;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d in_rdy", k), 32'(bus.in_rdy), 0);
      tick();
      chk($sformatf("stall%0d mem_vld", k),  32'(bus.mem_vld), 1);
      chk($sformatf("stall%0d mem_addr", k), 32'(bus.mem_addr), 40);
      chk($sformatf("stall%0d mem_data", k), 32'(bus.mem_data), 32'h66);
      chk($sformatf("stall%0d mem_we", k),   32'(bus.mem_we), 1);
    end
    chk("stall_cnt", 32'(stall_cnt), 32'(STALL_EXP));
    bus.mem_rdy = 1'b1;
    feed("bp[6]", 8'h77, 8'd48, 2'd1);

    // Abort after 7 W elements, with an element offered in the same cycle.
    abort = 1'b1;
    bus.in_data = 8'h88;
    tick();
    abort = 1'b0;
    bus.in_vld = 1'b0;
    chk("abort load_state", 32'(load_state), 0);
    chk("abort mem_vld",    32'(bus.mem_vld), 0);
    chk("abort done",       32'(done), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post-abort%0d done", k), 32'(done), 0);
      chk($sformatf("post-abort%0d state", k), 32'(load_state), 0);
    end

    // Restart after abort reloads from index 0; stall count restarts too.
    pulse_start();
    chk("restart stall_cnt", 32'(stall_cnt), 0);
    for (int i = 0; i < 3; i++)
      feed($sformatf("re[%0d]", i), vecs[i].data, vecs[i].addr, 2'd1);

    // A start during LOAD_W is ignored.
    bus.in_vld = 1'b0;
    pulse_start();
    chk("ignored start state", 32'(load_state), 1);
    for (int i = 3; i < 18; i++)
      feed($sformatf("re[%0d]", i), vecs[i].data, vecs[i].addr, vecs[i].state);

    // Asynchronous reset in the middle of LOAD_X while a beat is pending.
    bus.in_vld = 1'b0;
    bus.mem_rdy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    tick();
    chk_all_zero("reset held");
    #2;
    rst_n = 1'b1;
    bus.mem_rdy = 1'b1;
    bus.in_vld = 1'b1;
    tick();
    chk("after reset state",  32'(load_state), 0);
    chk("after reset in_rdy", 32'(bus.in_rdy), 0);
    bus.in_vld = 1'b0;
    pulse_start();
    feed("post-reset[0]", 8'h5A, 8'd0, 2'd1);
    bus.in_vld = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
